// File: rtl/fir_cfg_pkg.sv
// Shared definitions for the FIR configuration slave: register map, ap_ctrl bit
// positions and the read-channel state encoding.
package fir_cfg_pkg;

    localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
    localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
    localparam logic [11:0] ADDR_TAP_BASE = 12'h040;

    localparam int AP_START_BIT  = 0;
    localparam int AP_DONE_BIT   = 1;
    localparam int AP_IDLE_BIT   = 2;
    localparam int AP_IRQ_EN_BIT = 3;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MEM,
        R_WAIT,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/fir_ap_ctrl.sv
// ap_ctrl register block: start pulse, sticky done, idle tracking and, when
// AP_DONE_IRQ_EN is defined, the irq enable bit and registered irq output.
module fir_ap_ctrl
    import fir_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_data,
    input  logic        done_in,
    input  logic        done_clr,
    output logic        start_pulse,
    output logic        idle,
    output logic [31:0] status
`ifdef AP_DONE_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic done;
    logic irq_en_bit;
    logic start_ok;

    // A start request is honoured only when the engine is idle; bit0 itself is never stored.
    assign start_ok = wr_en && wr_data[AP_START_BIT] && idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pulse <= 1'b0;
            done        <= 1'b0;
            idle        <= 1'b1;
        end else begin
            start_pulse <= start_ok;
            if (done_in) begin
                // A completion pulse wins over a read-clear landing in the same cycle.
                done <= 1'b1;
                idle <= 1'b1;
            end else begin
                if (done_clr) begin
                    done <= 1'b0;
                end
                if (start_ok) begin
                    idle <= 1'b0;
                end
            end
        end
    end

`ifdef AP_DONE_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_en) begin
                irq_en <= wr_data[AP_IRQ_EN_BIT];
            end
            irq <= done && irq_en;
        end
    end

    assign irq_en_bit = irq_en;
`else
    logic unused_irq_bit;

    assign unused_irq_bit = wr_data[AP_IRQ_EN_BIT];
    assign irq_en_bit     = 1'b0;
`endif

    always_comb begin
        status                = '0;
        status[AP_START_BIT]  = 1'b0;
        status[AP_DONE_BIT]   = done;
        status[AP_IDLE_BIT]   = idle;
        status[AP_IRQ_EN_BIT] = irq_en_bit;
    end

endmodule

// File: rtl/axilite_fir_cfg.sv
// AXI-Lite slave decoding writes/reads into FIR control registers and the tap RAM port.
// Optional feature macro: AP_DONE_IRQ_EN (adds ap_ctrl bit3 irq_en and output irq_o).
module axilite_fir_cfg
    import fir_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   ap_start_o,
    input  logic                   ap_done_i,
    output logic [31:0]            data_length_o
`ifdef AP_DONE_IRQ_EN
    ,
    output logic                   irq_o
`endif
);

    localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(ADDR_DATA_LEN);
    localparam logic [pADDR_WIDTH-1:0] A_TAP  = pADDR_WIDTH'(ADDR_TAP_BASE);

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        logic [pADDR_WIDTH-1:0] off;
        off = a - A_TAP;
        return (a >= A_TAP) && (off[1:0] == 2'b00) && ((off >> 2) < pADDR_WIDTH'(Tape_Num));
    endfunction

    logic                   aw_held;
    logic                   w_held;
    logic [pADDR_WIDTH-1:0] aw_addr;
    logic [pDATA_WIDTH-1:0] w_data;
    logic                   commit;
    logic                   wr_ctrl;
    logic                   wr_len;
    logic                   wr_tap;
    logic [31:0]            data_length;
    logic                   ap_idle;
    logic [31:0]            ap_status;
    logic                   done_clr;

    rd_state_e              rd_state;
    rd_state_e              rd_state_n;
    logic [pADDR_WIDTH-1:0] rd_off;
    logic                   rd_ctrl;
    logic                   mem_rd;
    logic                   ar_tap_go;
    logic [pDATA_WIDTH-1:0] reg_rdata;

    // Write address and data are held independently; the cycle both are present is the commit.
    assign awready = !aw_held;
    assign wready  = !w_held;
    assign commit  = aw_held && w_held;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_held <= 1'b1;
                aw_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_held <= 1'b1;
                w_data <= wdata;
            end
        end
    end

    // Tap and length writes are locked out while the engine is running.
    assign wr_ctrl = commit && (aw_addr == A_CTRL);
    assign wr_len  = commit && (aw_addr == A_LEN) && ap_idle;
    assign wr_tap  = commit && is_tap(aw_addr) && ap_idle;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            data_length <= '0;
        end else if (wr_len) begin
            data_length <= 32'(w_data);
        end
    end

    assign data_length_o = data_length;

    fir_ap_ctrl u_ap_ctrl (
        .clk         (axis_clk),
        .rst_n       (axis_rst_n),
        .wr_en       (wr_ctrl),
        .wr_data     (w_data[3:0]),
        .done_in     (ap_done_i),
        .done_clr    (done_clr),
        .start_pulse (ap_start_o),
        .idle        (ap_idle),
        .status      (ap_status)
`ifdef AP_DONE_IRQ_EN
        ,
        .irq         (irq_o)
`endif
    );

    // Value returned for anything answered straight from registers (incl. busy tap reads).
    always_comb begin
        reg_rdata = '0;
        if (araddr == A_CTRL) begin
            reg_rdata = pDATA_WIDTH'(ap_status);
        end else if (araddr == A_LEN) begin
            reg_rdata = pDATA_WIDTH'(data_length);
        end else if (is_tap(araddr)) begin
            reg_rdata = '1;
        end
    end

    assign ar_tap_go = is_tap(araddr) && ap_idle;

    always_comb begin
        rd_state_n = rd_state;
        arready    = 1'b0;
        rvalid     = 1'b0;
        mem_rd     = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rd_state_n = ar_tap_go ? R_MEM : R_RESP;
                end
            end
            R_MEM: begin
                // The single RAM port goes to a committing write first; the read retries.
                if (!wr_tap) begin
                    mem_rd     = 1'b1;
                    rd_state_n = R_WAIT;
                end
            end
            R_WAIT: begin
                rd_state_n = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    rd_state_n = R_IDLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rd_state <= R_IDLE;
            rd_off   <= '0;
            rd_ctrl  <= 1'b0;
            rdata    <= '0;
        end else begin
            rd_state <= rd_state_n;
            if (rd_state == R_IDLE && arvalid) begin
                rd_off  <= araddr - A_TAP;
                rd_ctrl <= (araddr == A_CTRL);
                if (!ar_tap_go) begin
                    rdata <= reg_rdata;
                end
            end
            if (rd_state == R_WAIT) begin
                rdata <= tap_Do;
            end
        end
    end

    // Only a read that actually returned done=1 clears it.
    assign done_clr = (rd_state == R_RESP) && rready && rd_ctrl && rdata[AP_DONE_BIT];

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = rd_off;
        tap_Di = w_data;
        if (wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = aw_addr - A_TAP;
        end else if (mem_rd) begin
            tap_EN = 1'b1;
        end
    end

endmodule

// File: tb/tb_axilite_fir_cfg.sv
// Scoreboard bench for axilite_fir_cfg: read responses are checked against a queue of
// hand-computed values; control outputs are checked directly. Honours AP_DONE_IRQ_EN.
module tb_axilite_fir_cfg;

    logic        clk;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        tap_EN;
    logic [3:0]  tap_WE;
    logic [11:0] tap_A;
    logic [31:0] tap_Di, tap_Do;
    logic        ap_start_o, ap_done_i;
    logic [31:0] data_length_o;
`ifdef AP_DONE_IRQ_EN
    logic        irq_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [0:15];

    axilite_fir_cfg dut (
        .axis_clk      (clk),
        .axis_rst_n    (rst_n),
        .awvalid       (awvalid),
        .awready       (awready),
        .awaddr        (awaddr),
        .wvalid        (wvalid),
        .wready        (wready),
        .wdata         (wdata),
        .arvalid       (arvalid),
        .arready       (arready),
        .araddr        (araddr),
        .rvalid        (rvalid),
        .rready        (rready),
        .rdata         (rdata),
        .tap_EN        (tap_EN),
        .tap_WE        (tap_WE),
        .tap_A         (tap_A),
        .tap_Di        (tap_Di),
        .tap_Do        (tap_Do),
        .ap_start_o    (ap_start_o),
        .ap_done_i     (ap_done_i),
        .data_length_o (data_length_o)
`ifdef AP_DONE_IRQ_EN
        ,
        .irq_o         (irq_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port tap RAM with one cycle read latency.
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) begin
                mem[tap_A[5:2]] <= tap_Di;
                tap_Do <= tap_Di;
            end else begin
                tap_Do <= mem[tap_A[5:2]];
            end
        end
    end

    always @(negedge clk) begin
        if (ap_start_o) start_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every R handshake pops one expected response.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", rdata, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rdata@%03h", e.addr), rdata, e.data);
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input int w_lead);
        int   n;
        logic aw_hs, w_hs, aw_pend;
        n = 0;
        @(posedge clk); #1;
        awaddr  = a;
        wdata   = d;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        aw_pend = (w_lead != 0);
        while (awvalid || wvalid || aw_pend) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            if (w_lead > 0 && n == 1) check("wready_while_held", {31'b0, wready}, 32'h0);
            if (aw_pend && n >= w_lead) begin
                awvalid = 1'b1;
                aw_pend = 1'b0;
            end
            if (n > 50) begin
                check("wr_timeout", 32'(n), 32'd0);
                awvalid = 1'b0;
                wvalid  = 1'b0;
                aw_pend = 1'b0;
            end
        end
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input int exp_lat,
                            input int hold, input bit done_at_hs);
        int lat;
        exp_q.push_back('{addr: a, data: exp});
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        lat     = 0;
        while (arvalid) begin
            @(negedge clk);
            if (arready) begin
                @(posedge clk); #1;
                arvalid = 1'b0;
            end else begin
                @(posedge clk); #1;
                lat++;
                if (lat > 50) begin
                    check("ar_timeout", 32'(lat), 32'd0);
                    arvalid = 1'b0;
                end
            end
        end
        lat = 1;
        @(negedge clk);
        while (!rvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        if (!rvalid) begin
            check("r_timeout", 32'(lat), 32'd0);
            void'(exp_q.pop_back());
            return;
        end
        if (exp_lat > 0) check($sformatf("latency@%03h", a), 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rvalid_hold", {31'b0, rvalid}, 32'h1);
            check("rdata_hold", rdata, exp);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        if (done_at_hs) ap_done_i = 1'b1;
        @(posedge clk); #1;
        rready    = 1'b0;
        ap_done_i = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        ap_done_i = 1'b1;
        @(posedge clk); #1;
        ap_done_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; ap_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("awready_rst", {31'b0, awready}, 32'h1);
        check("wready_rst", {31'b0, wready}, 32'h1);
        check("arready_rst", {31'b0, arready}, 32'h1);
        check("rvalid_rst", {31'b0, rvalid}, 32'h0);
        check("tap_en_rst", {31'b0, tap_EN}, 32'h0);
        check("start_rst", {31'b0, ap_start_o}, 32'h0);
        check("len_rst", data_length_o, 32'h0);
        axi_read(12'h000, 32'h4, 1, 0, 0);

        // Tap programming and readback
        for (int i = 0; i < 11; i++)
            axi_write(12'h040 + 12'(4 * i), 32'(i + 1), (i == 3) ? 2 : 0);
        for (int i = 0; i < 11; i++)
            axi_read(12'h040 + 12'(4 * i), 32'(i + 1), 3, 0, 0);

        // Start and busy lockout
        axi_write(12'h010, 32'd600, 0);
        axi_read(12'h010, 32'd600, 1, 0, 0);
        check("len_out", data_length_o, 32'd600);
        start_cnt = 0;
        axi_write(12'h000, 32'h1, 0);
        repeat (3) @(posedge clk);
        check("start_pulses", 32'(start_cnt), 32'd1);
        axi_read(12'h000, 32'h0, 1, 0, 0);
        axi_write(12'h000, 32'h1, 0);
        axi_write(12'h040, 32'h55, 0);
        axi_write(12'h010, 32'd7, 0);
        repeat (3) @(posedge clk);
        check("start_busy_ignored", 32'(start_cnt), 32'd1);
        check("len_busy_dropped", data_length_o, 32'd600);
        axi_read(12'h040, 32'hFFFF_FFFF, 0, 0, 0);

        // Done, read-clear, and done coincident with clear
        pulse_done();
        axi_read(12'h000, 32'h6, 1, 0, 0);
        axi_read(12'h000, 32'h4, 1, 0, 0);
        axi_read(12'h040, 32'h1, 3, 0, 0);
        axi_write(12'h000, 32'h1, 0);
        pulse_done();
        axi_read(12'h000, 32'h6, 1, 0, 1);
        axi_read(12'h000, 32'h6, 1, 0, 0);
        axi_read(12'h000, 32'h4, 1, 0, 0);

        // Read/write collision on the tap port, stalled R channel, unmapped address
        fork
            axi_write(12'h044, 32'h0000_ABCD, 0);
            axi_read(12'h044, 32'h0000_ABCD, 4, 5, 0);
        join
        axi_write(12'h0F0, 32'h5, 0);
        axi_read(12'h0F0, 32'h0, 1, 0, 0);

        // Optional irq
        axi_write(12'h000, 32'h8, 0);
`ifdef AP_DONE_IRQ_EN
        axi_read(12'h000, 32'hC, 1, 0, 0);
        axi_write(12'h000, 32'h9, 0);
        axi_read(12'h000, 32'h8, 1, 0, 0);
        pulse_done();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("irq_set", {31'b0, irq_o}, 32'h1);
        axi_read(12'h000, 32'hE, 1, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("irq_clear", {31'b0, irq_o}, 32'h0);
`else
        axi_read(12'h000, 32'h4, 1, 0, 0);
`endif

        repeat (5) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
